// File: rtl/mult_hilo_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_hilo_ctrl_if
//
// Purpose : Bundles the handshake between the HI/LO controller and the
//           Booth multiplier.
//
// Signals :
//   mul_start   controller -> multiplier  one-cycle start pulse
//   mul_a/b     controller -> multiplier  registered 16-bit signed operands
//   mul_ready   multiplier -> controller  low while busy, high when done
//   mul_result  multiplier -> controller  32-bit signed product
//
// Modports: master = controller side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface mult_hilo_ctrl_if;
   logic        mul_start;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        mul_ready;
   logic [31:0] mul_result;

   modport master (
      output mul_start,
      output mul_a,
      output mul_b,
      input  mul_ready,
      input  mul_result
   );

   modport slave (
      input  mul_start,
      input  mul_a,
      input  mul_b,
      output mul_ready,
      output mul_result
   );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// mult_hilo_ctrl
//
// Purpose : Sequences a multi-cycle Booth multiply for a mult instruction in
//           EX and writes the 32-bit product into the HI/LO registers.
//           After reset the block drains for QUIET_CYCLES cycles so that a
//           multiply still in flight from before the reset cannot complete.
//           An operation completes only after the multiplier has been seen
//           to drop mul_ready and then raise it again; a watchdog aborts
//           operations where that sequence does not arrive in time.
//
// Ports   :
//   clk, rst          clock, synchronous active-high reset
//   req_valid         mult instruction present in EX
//   req_a, req_b      16-bit signed operands
//   req_acc           accumulate request (only used with HILO_MADD_ACC_EN)
//   mul               multiplier handshake (mult_hilo_ctrl_if.master)
//   stall             pipeline stall, high whenever the FSM is not IDLE
//   hi, lo            HI/LO architectural registers
//   done              one-cycle pulse while the freshly written HI/LO shows
//   err               sticky watchdog error, cleared only by rst
//
// Configuration:
//   HILO_MADD_ACC_EN  when defined, a captured req_acc=1 adds the product to
//                     {hi,lo} (modulo 2^32) instead of overwriting it.
// -----------------------------------------------------------------------------
module mult_hilo_ctrl #(
   parameter int QUIET_CYCLES = 20,
   parameter int WAIT_LIMIT   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic [15:0]            req_a,
   input  logic [15:0]            req_b,
   input  logic                   req_acc,
   mult_hilo_ctrl_if.master       mul,
   output logic                   stall,
   output logic [15:0]            hi,
   output logic [15:0]            lo,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [2:0] {
      S_QUIET,
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HI,
      S_WRITE
   } state_t;

   // One shared counter serves the drain, the WAIT_LOW and WAIT_HI timers.
   localparam int CNT_MAX = (QUIET_CYCLES > WAIT_LIMIT) ? QUIET_CYCLES : WAIT_LIMIT;
   localparam int CNT_W   = (CNT_MAX < 4) ? 2 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] QUIET_LAST    = CNT_W'(QUIET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_HI_LAST  = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [CNT_W-1:0] WAIT_LOW_LAST = CNT_W'(3);

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               mul_start_q, mul_start_d;
   logic [15:0]        mul_a_q,     mul_a_d;
   logic [15:0]        mul_b_q,     mul_b_d;
   logic [31:0]        hilo_q,      hilo_d;
   logic               done_q,      done_d;
   logic               err_q,       err_d;
   logic [31:0]        wr_value;

`ifdef HILO_MADD_ACC_EN
   logic               acc_q,       acc_d;

   // Accumulate wraps modulo 2^32; no saturation.
   assign wr_value = acc_q ? (hilo_q + mul.mul_result) : mul.mul_result;
`else
   logic               unused_req_acc;

   assign unused_req_acc = req_acc;
   assign wr_value       = mul.mul_result;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      hilo_d  = hilo_q;
      err_d   = err_q;
`ifdef HILO_MADD_ACC_EN
      acc_d   = acc_q;
`endif

      unique case (state_q)
         S_QUIET: begin
            // mul_ready is deliberately not looked at while draining.
            if (cnt_q == QUIET_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_IDLE: begin
            if (req_valid) begin
               mul_a_d = req_a;
               mul_b_d = req_b;
`ifdef HILO_MADD_ACC_EN
               acc_d   = req_acc;
`endif
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT_LOW;
            cnt_d   = '0;
         end

         S_WAIT_LOW: begin
            // A ready that is still high here may be stale; wait for it to
            // drop so that the next rising ready belongs to this operation.
            if (!mul.mul_ready) begin
               state_d = S_WAIT_HI;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_LOW_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WAIT_HI: begin
            if (mul.mul_ready) begin
               hilo_d  = wr_value;
               state_d = S_WRITE;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_HI_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WRITE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_QUIET;
            cnt_d   = '0;
         end
      endcase

      // Registered outputs are derived from the next state so that they line
      // up exactly with the state they belong to.
      mul_start_d = (state_d == S_ISSUE);
      done_d      = (state_d == S_WRITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_QUIET;
         cnt_q       <= '0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         hilo_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef HILO_MADD_ACC_EN
         acc_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         hilo_q      <= hilo_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef HILO_MADD_ACC_EN
         acc_q       <= acc_d;
`endif
      end
   end

   assign stall         = (state_q != S_IDLE);
   assign mul.mul_start = mul_start_q;
   assign mul.mul_a     = mul_a_q;
   assign mul.mul_b     = mul_b_q;
   assign hi            = hilo_q[31:16];
   assign lo            = hilo_q[15:0];
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_hilo_ctrl
//
// Self-checking bench for mult_hilo_ctrl. A behavioural multiplier drops
// mul_ready one cycle after mul_start and raises it 17 cycles later with the
// product. Expected HI/LO values are queued when a request is driven and
// compared whenever done pulses.
// -----------------------------------------------------------------------------
module tb_mult_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic        req_acc = 1'b0;
   logic        stall;
   logic [15:0] hi;
   logic [15:0] lo;
   logic        done;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_seen = 0;
   int          model_mode = 0;     // 0: normal multiplier, 1: never drops ready
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mult_hilo_ctrl_if mif();

   mult_hilo_ctrl #(
      .QUIET_CYCLES (20),
      .WAIT_LIMIT   (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_acc   (req_acc),
      .mul       (mif),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo),
      .done      (done),
      .err       (err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Multiplier model
   initial begin
      logic signed [31:0] prod;
      mif.mul_ready  = 1'b1;
      mif.mul_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mif.mul_start === 1'b1 && model_mode == 0) begin
            prod = $signed(mif.mul_a) * $signed(mif.mul_b);
            @(posedge clk);
            #1 mif.mul_ready = 1'b0;
            repeat (17) @(posedge clk);
            #1;
            mif.mul_ready  = 1'b1;
            mif.mul_result = prod;
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         done_seen++;
         check_val("sb_depth_at_done", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            $display("[TB] txn done hi=%h lo=%h expected=%h", hi, lo, e);
            check_val("hilo_at_done", {hi, lo}, e);
         end
      end
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic acc,
                         input bit push, input logic [31:0] expv,
                         output int done_cyc, output int stall_cyc);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_acc   = acc;
      if (push) exp_q.push_back(expv);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("issue_mul_start", {31'd0, mif.mul_start}, 32'd1);
      check_val("issue_operands", {mif.mul_a, mif.mul_b}, {a, b});
      done_cyc  = 0;
      stall_cyc = 0;
      n = 1;
      while (stall === 1'b1 && n <= 200) begin
         stall_cyc++;
         if (done === 1'b1) done_cyc = n;
         @(negedge clk);
         n++;
      end
      check_val("op_returns_idle", {31'd0, stall}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, failures so far=%0d", n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      int dc, sc, n, dcount, d0;
      logic [31:0] saved;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_stall", {31'd0, stall}, 32'd1);
      check_val("rst_mul_start", {31'd0, mif.mul_start}, 32'd0);
      check_val("rst_mul_ab", {mif.mul_a, mif.mul_b}, 32'd0);
      check_val("rst_hilo", {hi, lo}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);

      // Post-reset drain length
      rst = 1'b0;
      n = 0;
      while (stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_val("quiet_len", n, 32'd20);

      // 3 * -5
      run_op(16'd3, 16'hFFFB, 1'b0, 1'b1, 32'hFFFF_FFF1, dc, sc);
      check_val("t1_done_cycle", dc, 32'd20);
      check_val("t1_stall_cycles", sc, 32'd20);
      check_val("t1_hi", {16'd0, hi}, 32'h0000_FFFF);
      check_val("t1_lo", {16'd0, lo}, 32'h0000_FFF1);

      // -32768 * -32768
      run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 32'h4000_0000, dc, sc);
      check_val("t2_hi", {16'd0, hi}, 32'h0000_4000);
      check_val("t2_lo", {16'd0, lo}, 32'h0000_0000);

      // Accumulate behaviour
      run_op(16'd4, 16'd4, 1'b0, 1'b1, 32'h0000_0010, dc, sc);
`ifdef HILO_MADD_ACC_EN
      run_op(16'd2, 16'd3, 1'b1, 1'b1, 32'h0000_0016, dc, sc);
      check_val("acc_hilo", {hi, lo}, 32'h0000_0016);
`else
      run_op(16'd2, 16'd3, 1'b1, 1'b1, 32'h0000_0006, dc, sc);
      check_val("acc_hilo", {hi, lo}, 32'h0000_0006);
`endif

      // req_valid held through an operation; operands change mid-way
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 16'd7;
      req_b     = 16'd9;
      req_acc   = 1'b0;
      exp_q.push_back(32'd63);
      d0 = done_seen;
      dcount = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 3) begin
            req_a = 16'd100;
            req_b = 16'd200;
         end
         check_val("held_operands", {mif.mul_a, mif.mul_b}, {16'd7, 16'd9});
         if (done === 1'b1) begin
            dcount++;
            req_valid = 1'b0;
         end
      end while (stall === 1'b1 && n < 200);
      repeat (3) @(negedge clk);
      check_val("held_one_done", dcount, 32'd1);
      check_val("held_no_restart", {31'd0, stall}, 32'd0);
      check_val("held_done_count", done_seen - d0, 32'd1);

      // Watchdog: multiplier never drops ready
      saved = {hi, lo};
      model_mode = 1;
      d0 = done_seen;
      run_op(16'd5, 16'd5, 1'b0, 1'b0, 32'd0, dc, sc);
      check_val("wd_stall_cycles", sc, 32'd5);
      check_val("wd_err", {31'd0, err}, 32'd1);
      check_val("wd_hilo_kept", {hi, lo}, saved);
      check_val("wd_no_done", done_seen - d0, 32'd0);
      model_mode = 0;

      // err is sticky across a good operation
      run_op(16'd1, 16'd1, 1'b0, 1'b1, 32'd1, dc, sc);
      check_val("err_sticky", {31'd0, err}, 32'd1);

      // Reset in WAIT_HI; the aborted multiply raises ready during QUIET
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 16'd11;
      req_b     = 16'd13;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (7) @(negedge clk);
      d0 = done_seen;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_hilo", {hi, lo}, 32'd0);
      check_val("midrst_err", {31'd0, err}, 32'd0);
      n = 0;
      while (stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_val("midrst_quiet_len", n, 32'd20);
      check_val("midrst_no_done", done_seen - d0, 32'd0);

      // Recovery with ready idling high from the stale pulse
      run_op(16'hFFFF, 16'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, dc, sc);
      check_val("recover_done_cycle", dc, 32'd20);
      check_val("recover_hilo", {hi, lo}, 32'hFFFF_FFFF);

      repeat (2) @(negedge clk);
      check_val("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
